dense_layer_bwd: RTL and testbench
==================================

# dense_layer_bwd

Backward-pass companion to the dense-layer neuron core. Given the output error `delta` for one neuron, it streams per-input gradients `grad_x[i] = delta*w[i]` and SGD-updated weights `w[i] - ((delta*x[i]) >>> LR_SHIFT)`, one element per cycle under valid/ready backpressure. It also produces an updated bias. It sits between the loss/error stage and the weight store, reading the same `input_x`/`weights` arrays the forward core consumes.

## Interface
- `N`, 64, number of inputs/weights per neuron.
- `DW`, 32, data width, signed two's complement.
- `LR_SHIFT`, 4, learning-rate shift; arithmetic right shift applied to the gradient.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `input_x` in `[0:N-1]` x DW signed: forward activations. Must be stable from start handshake until `done`.
- `weights` in `[0:N-1]` x DW signed: current weights, same stability rule.
- `bias` in DW signed: current bias, sampled at the start handshake.
- `delta` in DW signed: output error, sampled at the start handshake.
- `start_valid` in 1: request a backward pass.
- `start_ready` out 1: high only in IDLE.
- `out_valid` out 1: the element outputs are valid.
- `out_ready` in 1: consumer accepts the element.
- `out_idx` out $clog2(N): index of the presented element.
- `grad_x` out DW signed: `delta*weights[out_idx]`.
- `weight_new` out DW signed: updated weight for `out_idx`.
- `bias_new` out DW signed: `bias - (delta >>> LR_SHIFT)`. Registered at start and held until the next start.
- `done` out 1: single-cycle pulse at the end of a pass.

## Operation
- States are IDLE, RUN and DRAIN.
- IDLE:
  - `start_ready=1`.
  - On `start_valid`, capture `delta_q`, compute `bias_new`, clear `idx`, then go to RUN.
- RUN:
  - Whenever the output slot is free (`!out_valid || out_ready`), register element `idx` into the slot, set `out_valid=1` and increment `idx`.
  - After loading `idx=N-1`, go to DRAIN.
- DRAIN:
  - When `out_valid && out_ready`, clear `out_valid`, pulse `done`, then go to IDLE.
- Arithmetic, each element:
  - `grad_x` = low DW bits of `delta_q*weights[i]`. Wraps on overflow and never saturates.
  - `gw` = low DW bits of `delta_q*input_x[i]`.
  - `weight_new` = `weights[i] - (gw >>> LR_SHIFT)`, wrapping.
  - Shifts are arithmetic and round toward negative infinity.
- `grad_x` always uses the pre-update weight.
- `start_valid` outside IDLE is ignored. `start_ready=0` there, and `delta_q`/`bias_new` do not change.
- Under backpressure the slot holds `out_idx`, `grad_x` and `weight_new` stable. No element is skipped or duplicated.
- Reset values are 0 for all outputs and registers: `out_valid`, `done`, `out_idx`, `grad_x`, `weight_new` and `bias_new`. `start_ready` is 1 once reset has been sampled low (state IDLE).
- Reset mid-pass aborts with no `done`. The next pass restarts at `idx=0`.

## Timing
- Start handshake at cycle T: `bias_new` is valid at T+1, and element 0 is presented at T+2.
- With `out_ready` held high, element k is presented at T+2+k, one per cycle.
- `done` pulses at T+N+2 (the cycle after the last handshake). `start_ready` returns high in that same cycle.
- A new start may be accepted in the `done` cycle.
- Each cycle of `out_ready=0` adds one cycle to the pass.
- `done` never coincides with `out_valid`.

## Structure
- Shared package `dense_layer_pkg` holds:
  - constants `DENSE_N=64`, `DENSE_DW=32`;
  - typedef `dense_word_t` (signed DW);
  - enum `bwd_state_t` {IDLE, RUN, DRAIN}.
- Sub-module `dense_layer_bwd_pe` is combinational.
  - Inputs: `delta_q`, `x`, `w`.
  - Outputs: `grad_x`, `weight_new`.
  - Holds the multiply, truncate and shift rules in one place.
- The top level holds the FSM, `idx` counter, output slot and `bias_new` register.

## Test plan
- Nominal pass, `out_ready` held high:
  - Stimulus: `delta=2`, `x[i]=i`, `w[i]=1`, `bias=10`.
  - `grad_x`=2 for all elements; `bias_new`=10.
  - `weight_new`: idx 0 gives 1, idx 8 gives 0, idx 63 gives -6.
  - Elements appear at T+2..T+65 and `done` pulses at T+66.
- Signed/shift:
  - Stimulus: `delta=-16`, `x[0]=3`, `w[0]=-5`, `bias=0`.
  - `grad_x[0]=80`, `weight_new[0]=-2`, `bias_new=1`.
- Overflow wrap:
  - Stimulus: `delta=32'h4000_0000`, `w[3]=4`, `x[3]=0`.
  - `grad_x[3]=0`, `weight_new[3]=4`, with no error flag.
- Backpressure:
  - Drop `out_ready` for 3 cycles while `out_idx=5` is presented.
  - Outputs stay frozen at idx 5, each index 0..63 is accepted exactly once, and `done` is delayed by 3 cycles.
- Busy start:
  - Assert `start_valid` with `delta=99` during RUN.
  - `start_ready=0` and results keep using the original `delta`.
- Mid-pass reset:
  - Assert `rst_n=0` for one cycle at `out_idx=20`.
  - Next cycle: `out_valid=0`, `start_ready=1`, all outputs 0, and no `done`.
  - A new start presents idx 0 first.

Source files
------------

// File: rtl/dense_layer_pkg.sv
// Shared types and sizing for the dense-layer neuron cores.
package dense_layer_pkg;
  localparam int DENSE_N  = 64;
  localparam int DENSE_DW = 32;

  typedef logic signed [DENSE_DW-1:0] dense_word_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} bwd_state_t;
endpackage

// File: rtl/dense_layer_bwd_if.sv
// Start/stream bundle between the error stage, dense_layer_bwd and the weight store.
interface dense_layer_bwd_if #(
  parameter int N  = dense_layer_pkg::DENSE_N,
  parameter int DW = dense_layer_pkg::DENSE_DW
);
  localparam int IW = $clog2(N);

  logic signed [DW-1:0] input_x [0:N-1];
  logic signed [DW-1:0] weights [0:N-1];
  logic signed [DW-1:0] bias;
  logic signed [DW-1:0] delta;
  logic                 start_valid;
  logic                 start_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_idx;
  logic signed [DW-1:0] grad_x;
  logic signed [DW-1:0] weight_new;
  logic signed [DW-1:0] bias_new;
  logic                 done;

  modport master (
    output input_x, weights, bias, delta, start_valid, out_ready,
    input  start_ready, out_valid, out_idx, grad_x, weight_new, bias_new, done
  );

  modport slave (
    input  input_x, weights, bias, delta, start_valid, out_ready,
    output start_ready, out_valid, out_idx, grad_x, weight_new, bias_new, done
  );
endinterface

// File: rtl/dense_layer_bwd_pe.sv
// Per-element backward arithmetic: wrapping products and the floor-shift SGD update.
module dense_layer_bwd_pe #(
  parameter int DW       = 32,
  parameter int LR_SHIFT = 4
) (
  input  logic signed [DW-1:0] delta_q,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  output logic signed [DW-1:0] grad_x,
  output logic signed [DW-1:0] weight_new
);
  logic signed [DW-1:0] gw;

  // Same-width multiplies keep only the low DW bits, which is the wrap we want.
  assign grad_x     = delta_q * w;
  assign gw         = delta_q * x;
  assign weight_new = w - (gw >>> LR_SHIFT);
endmodule

// File: rtl/dense_layer_bwd.sv
// dense_layer_bwd: streams grad_x and SGD-updated weights for one neuron, one element per slot.
// IDLE waits for start | RUN loads element idx whenever the slot frees | DRAIN waits for the last accept.
module dense_layer_bwd
  import dense_layer_pkg::*;
#(
  parameter int N        = DENSE_N,
  parameter int DW       = DENSE_DW,
  parameter int LR_SHIFT = 4
) (
  input logic              clk,
  input logic              rst_n,
  dense_layer_bwd_if.slave bus
);
  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  bwd_state_t           state, state_nx;
  logic                 capture, load, finish;
  logic [IW-1:0]        idx, out_idx_q;
  logic signed [DW-1:0] delta_q, bias_new_q, grad_q, wnew_q;
  logic signed [DW-1:0] pe_grad, pe_wnew;
  logic                 out_valid_q, done_q;

  dense_layer_bwd_pe #(.DW(DW), .LR_SHIFT(LR_SHIFT)) u_pe (
    .delta_q   (delta_q),
    .x         (bus.input_x[idx]),
    .w         (bus.weights[idx]),
    .grad_x    (pe_grad),
    .weight_new(pe_wnew)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    load     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          capture  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!out_valid_q || bus.out_ready) begin
          load = 1'b1;
          if (idx == LAST_IDX) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      delta_q     <= '0;
      bias_new_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      grad_q      <= '0;
      wnew_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish;
      if (capture) begin
        delta_q    <= bus.delta;
        bias_new_q <= bus.bias - (bus.delta >>> LR_SHIFT);
        idx        <= '0;
      end
      // A load in RUN doubles as the accept of whatever the slot held.
      if (load) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= idx;
        grad_q      <= pe_grad;
        wnew_q      <= pe_wnew;
        idx         <= idx + IW'(1);
      end else if (finish) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.grad_x      = grad_q;
  assign bus.weight_new  = wnew_q;
  assign bus.bias_new    = bias_new_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_dense_layer_bwd.sv
// Randomized scoreboard bench for dense_layer_bwd against a plain-arithmetic reference model.
module tb_dense_layer_bwd;
  import dense_layer_pkg::*;

  localparam int N  = DENSE_N;
  localparam int LR = 4;

  typedef struct {
    int idx;
    int grad;
    int wn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   in_done_cycle = 1'b0;

  dense_word_t xm [N];
  dense_word_t wm [N];
  exp_t        sb [$];
  exp_t        mon_e;

  dense_layer_bwd_if bus ();

  dense_layer_bwd dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
    else n_pass++;
  endtask

  // floor(v / 2^LR), done with division so it is independent of shift semantics
  function automatic longint floor_div(input int v);
    longint q;
    q = longint'(v) / (longint'(1) << LR);
    if (v < 0 && (longint'(v) % (longint'(1) << LR)) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int ref_grad(input int d, input int w);
    return int'(longint'(d) * longint'(w));
  endfunction

  function automatic int ref_wnew(input int d, input int x, input int w);
    int gw;
    gw = int'(longint'(d) * longint'(x));
    return int'(longint'(w) - floor_div(gw));
  endfunction

  function automatic int rnd_word();
    if ($urandom_range(1) == 0) return int'($urandom);
    return int'($urandom_range(400)) - 200;
  endfunction

  task automatic load_arrays(input bit nominal);
    for (int i = 0; i < N; i++) begin
      xm[i] = nominal ? dense_word_t'(i) : dense_word_t'(rnd_word());
      wm[i] = nominal ? dense_word_t'(1) : dense_word_t'(rnd_word());
    end
  endtask

  task automatic drive_arrays();
    for (int i = 0; i < N; i++) begin
      bus.input_x[i] = xm[i];
      bus.weights[i] = wm[i];
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) chk("done_vs_valid", bus.out_valid, 0);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("out_idx", bus.out_idx, mon_e.idx);
        chk("grad_x", bus.grad_x, mon_e.grad);
        chk("weight_new", bus.weight_new, mon_e.wn);
      end
    end
  end

  // mode: 0 ready high, 1 stall at idx 5, 2 busy start at idx 10, 3 reset at idx 20, 4 random ready
  task automatic run_pass(input int d, input int b, input int mode);
    int t0;
    int bp_cnt = 0;
    int exp_bias;
    bit seen = 1'b0;
    bit done_seen = 1'b0;
    bit busy_done = 1'b0;
    logic [5:0] f_idx;
    logic signed [31:0] f_g, f_w;

    drive_arrays();
    if (!in_done_cycle) begin
      @(posedge clk); #1;
    end
    in_done_cycle = 1'b0;
    chk("start_ready_idle", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.delta       = d;
    bus.bias        = b;
    bus.out_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.delta       = rnd_word();
    bus.bias        = rnd_word();
    t0 = cyc;
    exp_bias = int'(longint'(b) - floor_div(d));
    chk("bias_new", bus.bias_new, exp_bias);
    chk("start_ready_busy", bus.start_ready, 0);
    for (int i = 0; i < N; i++)
      sb.push_back('{i, ref_grad(d, wm[i]), ref_wnew(d, xm[i], wm[i])});

    while (!done_seen && (cyc - t0) < 400) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_seen = 1'b1;
        if (mode != 4) chk("done_latency", cyc - t0, N + 1 + ((mode == 1) ? 3 : 0));
        chk("start_ready_done", bus.start_ready, 1);
        chk("bias_hold", bus.bias_new, exp_bias);
      end else begin
        bus.start_valid = 1'b0;
        bus.out_ready   = (mode == 4) ? ($urandom_range(3) != 0) : 1'b1;
        if (bus.out_valid && !seen) begin
          seen = 1'b1;
          chk("first_idx", bus.out_idx, 0);
          chk("first_latency", cyc - t0, 1);
        end
        if (mode == 1 && bus.out_valid && bus.out_idx == 6'd5 && bp_cnt <= 3) begin
          if (bp_cnt == 0) begin
            f_idx = bus.out_idx; f_g = bus.grad_x; f_w = bus.weight_new;
          end else begin
            chk("stall_idx", bus.out_idx, f_idx);
            chk("stall_grad", bus.grad_x, f_g);
            chk("stall_wnew", bus.weight_new, f_w);
          end
          if (bp_cnt < 3) bus.out_ready = 1'b0;
          bp_cnt++;
        end
        if (mode == 2 && bus.out_valid && bus.out_idx == 6'd10 && !busy_done) begin
          busy_done = 1'b1;
          chk("busy_start_ready", bus.start_ready, 0);
          bus.start_valid = 1'b1;
          bus.delta       = 99;
          bus.bias        = 12345;
        end
        if (mode == 3 && bus.out_valid && bus.out_idx == 6'd20) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          chk("abort_valid", bus.out_valid, 0);
          chk("abort_ready", bus.start_ready, 1);
          chk("abort_done", bus.done, 0);
          chk("abort_idx", bus.out_idx, 0);
          chk("abort_grad", bus.grad_x, 0);
          chk("abort_wnew", bus.weight_new, 0);
          chk("abort_bias", bus.bias_new, 0);
          sb.delete();
          @(posedge clk); #1;
          chk("abort_no_done", bus.done, 0);
          return;
        end
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    chk("sb_empty", sb.size(), 0);
    in_done_cycle = done_seen;
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.out_ready   = 1'b1;
    bus.delta       = '0;
    bus.bias        = '0;
    load_arrays(1'b1);
    drive_arrays();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_grad", bus.grad_x, 0);
    chk("rst_wnew", bus.weight_new, 0);
    chk("rst_bias", bus.bias_new, 0);
    chk("rst_start_ready", bus.start_ready, 1);
    rst_n = 1'b1;

    load_arrays(1'b1);
    run_pass(2, 10, 0);

    load_arrays(1'b0);
    xm[0] = 3; wm[0] = -5;
    run_pass(-16, 0, 0);

    load_arrays(1'b0);
    xm[3] = 0; wm[3] = 4;
    run_pass(32'h4000_0000, rnd_word(), 0);

    load_arrays(1'b0);
    run_pass(rnd_word(), rnd_word(), 1);

    load_arrays(1'b0);
    run_pass(rnd_word(), rnd_word(), 2);

    load_arrays(1'b0);
    run_pass(rnd_word(), rnd_word(), 3);

    load_arrays(1'b0);
    run_pass(rnd_word(), rnd_word(), 0);

    for (int p = 0; p < 2; p++) begin
      load_arrays(1'b0);
      run_pass(rnd_word(), rnd_word(), 4);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
